// File: rtl/demux_4_pkg.sv
// Shared constants for the 1-to-4 stream demultiplexer.
// Channel indices are typed to the select width.
package demux_4_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  localparam logic [SEL_W-1:0] CH0 = 2'd0;
  localparam logic [SEL_W-1:0] CH1 = 2'd1;
  localparam logic [SEL_W-1:0] CH2 = 2'd2;
  localparam logic [SEL_W-1:0] CH3 = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear has priority over increment.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/demux_4_stream.sv
// 1-to-4 valid/ready demultiplexer with one holding register
// and a saturating beat counter per output channel.
module demux_4_stream
  import demux_4_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [1:0]              in_sel,
  output logic [3:0]              out_valid,
  input  logic [3:0]              out_ready,
  output logic [4*WIDTH-1:0]      out_data,
  input  logic                    cnt_clr,
  output logic [4*CNT_W-1:0]      beat_cnt
);

  logic             hold_vld;
  logic [SEL_W-1:0] hold_sel;
  logic [WIDTH-1:0] hold_data;
  logic             out_fire;
  logic             in_fire;

  assign out_fire = hold_vld && out_ready[hold_sel];
  // Drains and refills in one cycle, so no bubble between beats.
  assign in_ready = !hold_vld || out_fire;
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_vld  <= 1'b0;
      hold_sel  <= '0;
      hold_data <= '0;
    end else if (in_fire) begin
      hold_vld  <= 1'b1;
      hold_sel  <= in_sel;
      hold_data <= in_data;
    end else if (out_fire) begin
      hold_vld  <= 1'b0;
    end
  end

  always_comb begin
    out_valid = 4'b0000;
    if (hold_vld) begin
      unique case (hold_sel)
        CH0: out_valid = 4'b0001;
        CH1: out_valid = 4'b0010;
        CH2: out_valid = 4'b0100;
        CH3: out_valid = 4'b1000;
        default: out_valid = 4'b0000;
      endcase
    end
  end

  assign out_data = {NUM_CH{hold_data}};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt
    logic inc;
    assign inc = out_fire && (hold_sel == SEL_W'(i));

    sat_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .inc   (inc),
      .cnt   (beat_cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_demux_4_stream.sv
// Directed bench for demux_4_stream: routing, streaming,
// stall, mid-run reset and counter saturation/clear.
module tb_demux_4_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data;
  logic        cnt_clr;
  logic [31:0] beat_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  demux_4_stream #(
    .WIDTH (8),
    .CNT_W (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .cnt_clr   (cnt_clr),
    .beat_cnt  (beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_sel    = 2'd0;
    out_ready = 4'b0000;
    cnt_clr   = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_vld", 32'(out_valid), 32'h0);
    chk("rst_cnt", beat_cnt, 32'h0);
    chk("rst_rdy", 32'(in_ready), 32'h1);
    chk("rst_dat", out_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // route one beat to channel 2
    @(negedge clk);
    out_ready = 4'b1111;
    in_valid  = 1'b1;
    in_sel    = 2'd2;
    in_data   = 8'hA5;
    #1 chk("rt_rdy", 32'(in_ready), 32'h1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("rt_vld", 32'(out_valid), 32'h4);
    chk("rt_dat", 32'(out_data[23:16]), 32'hA5);
    @(negedge clk);
    #1;
    chk("rt_vld0", 32'(out_valid), 32'h0);
    chk("rt_cnt", beat_cnt, 32'h0001_0000);

    // back-to-back beats across all channels
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_sel   = 2'(k);
      in_data  = 8'(8'h10 + k);
      #1 chk("st_rdy", 32'(in_ready), 32'h1);
      if (k > 0) chk("st_vld", 32'(out_valid), 32'(1 << (k - 1)));
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    chk("st_vld3", 32'(out_valid), 32'h8);
    chk("st_dat3", 32'(out_data[31:24]), 32'h13);
    @(negedge clk);
    #1;
    chk("st_cnt", beat_cnt, 32'h0102_0101);

    // stall channel 1 with a second beat waiting
    out_ready = 4'b1101;
    in_valid  = 1'b1;
    in_sel    = 2'd1;
    in_data   = 8'h3C;
    #1 chk("sl_rdy0", 32'(in_ready), 32'h1);
    @(negedge clk);
    in_sel  = 2'd0;
    in_data = 8'h77;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("sl_rdy", 32'(in_ready), 32'h0);
      chk("sl_vld", 32'(out_valid), 32'h2);
      chk("sl_dat", 32'(out_data[15:8]), 32'h3C);
      @(negedge clk);
    end
    out_ready = 4'b1111;
    #1;
    chk("sl_rdy1", 32'(in_ready), 32'h1);
    chk("sl_vld1", 32'(out_valid), 32'h2);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("sl_vld0", 32'(out_valid), 32'h1);
    chk("sl_dat0", 32'(out_data[7:0]), 32'h77);
    @(negedge clk);
    #1;
    chk("sl_cnt", beat_cnt, 32'h0102_0202);

    // reset while a beat is held: it must vanish
    out_ready = 4'b0000;
    in_valid  = 1'b1;
    in_sel    = 2'd3;
    in_data   = 8'h5A;
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("mr_vld", 32'(out_valid), 32'h8);
    rst_n = 1'b0;
    #1;
    chk("mr_vld0", 32'(out_valid), 32'h0);
    chk("mr_rdy", 32'(in_ready), 32'h1);
    chk("mr_cnt", beat_cnt, 32'h0);
    chk("mr_dat", out_data, 32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 4'b1111;
    @(negedge clk);
    #1;
    chk("mr_drop", 32'(out_valid), 32'h0);
    chk("mr_cnt1", beat_cnt, 32'h0);

    // saturate channel 3, then clear against a same-cycle fire
    in_valid = 1'b1;
    in_sel   = 2'd3;
    in_data  = 8'hEE;
    repeat (300) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1 chk("sat_cnt", beat_cnt, 32'hFF00_0000);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cnt_clr  = 1'b1;
    #1 chk("clr_vld", 32'(out_valid), 32'h8);
    @(negedge clk);
    cnt_clr = 1'b0;
    #1;
    chk("clr_cnt", beat_cnt, 32'h0);
    chk("clr_vld0", 32'(out_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
